data_mem_responder: RTL

//  Memory-side responder for the processor's load/store port: accepts one request via a valid/ready handshake.

---
 rtl/data_mem_pkg.sv | 18 +
 rtl/load_store_align.sv | 45 ++++
 rtl/data_mem_responder.sv | 113 +++++++++++
 3 files changed

// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared types and RV64 funct3 codes for the data memory responder
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

endpackage

// File: rtl/load_store_align.sv
// rtl/load_store_align.sv - byte-lane extraction/extension for loads and lane merge for stores
module load_store_align
  import data_mem_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [2:0]  byte_off,
  input  logic [63:0] old_word,
  input  logic [63:0] wdata,
  output logic [63:0] load_value,
  output logic [63:0] store_word,
  output logic        misalign
);

  logic [5:0]  bit_off;
  logic [63:0] shifted;
  logic [63:0] size_mask;
  logic [63:0] lane_mask;

  always_comb begin
    bit_off = {byte_off, 3'b000};
    shifted = old_word >> bit_off;

    case (func3[1:0])
      2'd0:    begin size_mask = 64'h0000_0000_0000_00FF; misalign = 1'b0;           end
      2'd1:    begin size_mask = 64'h0000_0000_0000_FFFF; misalign = byte_off[0];    end
      2'd2:    begin size_mask = 64'h0000_0000_FFFF_FFFF; misalign = |byte_off[1:0]; end
      default: begin size_mask = 64'hFFFF_FFFF_FFFF_FFFF; misalign = |byte_off;      end
    endcase

    lane_mask  = size_mask << bit_off;
    store_word = (old_word & ~lane_mask) | ((wdata & size_mask) << bit_off);

    case (func3)
      F3_B:    load_value = {{56{shifted[7]}}, shifted[7:0]};
      F3_H:    load_value = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    load_value = {{32{shifted[31]}}, shifted[31:0]};
      F3_D:    load_value = shifted;
      F3_BU:   load_value = {56'h0, shifted[7:0]};
      F3_HU:   load_value = {48'h0, shifted[15:0]};
      F3_WU:   load_value = {32'h0, shifted[31:0]};
      default: load_value = 64'h0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - latency-modelling RV64 data memory with valid/ready request and response
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [63:0] BASE_ADDR   = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_func3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int IW = (DEPTH_WORDS < 2) ? 1 : $clog2(DEPTH_WORDS);
  localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

  resp_state_t state, next_state;
  logic [CW-1:0] cnt;
  logic          lat_write;
  logic [2:0]    lat_func3;
  logic [63:0]   lat_addr, lat_wdata;

  logic [63:0] mem [DEPTH_WORDS];

  logic          cur_write;
  logic [2:0]    cur_func3;
  logic [63:0]   cur_addr, cur_wdata, off;
  logic [IW-1:0] word_idx;
  logic          in_range, func_err, misalign, err, enter_resp;
  logic [63:0]   load_value, store_word;

  // With zero wait the access resolves on the accepting edge, so decode the live request there.
  always_comb begin
    cur_write = (state == IDLE) ? req_write : lat_write;
    cur_func3 = (state == IDLE) ? req_func3 : lat_func3;
    cur_addr  = (state == IDLE) ? req_addr  : lat_addr;
    cur_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    off       = cur_addr - BASE_ADDR;
    word_idx  = off[IW+2:3];
    in_range  = (cur_addr >= BASE_ADDR) && (off[63:3] < 61'(DEPTH_WORDS));
    func_err  = cur_write ? cur_func3[2] : (cur_func3 == 3'b111);
    err       = !in_range || misalign || func_err;
  end

  load_store_align u_align (
    .func3      (cur_func3),
    .byte_off   (off[2:0]),
    .old_word   (mem[word_idx]),
    .wdata      (cur_wdata),
    .load_value (load_value),
    .store_word (store_word),
    .misalign   (misalign)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid) next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (cnt == CW'(1)) next_state = RESP;
      RESP:    if (resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    enter_resp = (next_state == RESP) && (state != RESP);
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
  end

  // Storage sits in the reset block only so an aborted store can never commit; it is never cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      lat_write  <= 1'b0;
      lat_func3  <= 3'b000;
      lat_addr   <= 64'h0;
      lat_wdata  <= 64'h0;
      resp_rdata <= 64'h0;
      resp_err   <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        lat_write <= req_write;
        lat_func3 <= req_func3;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        cnt       <= CW'(WAIT_CYCLES);
      end else if (state == WAIT) begin
        cnt <= cnt - CW'(1);
      end
      if (enter_resp) begin
        resp_err   <= err;
        resp_rdata <= (err || cur_write) ? 64'h0 : load_value;
        if (cur_write && !err) mem[word_idx] <= store_word;
      end
    end
  end

endmodule
